// File: rtl/ps2_dir_decoder.sv
// PS/2 scancode to key-event and player-direction decoder.
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   ps2_code_new, ps2_code  : byte strobe (level) and scancode
//   dir1, dir2              : player directions (UP=0 DOWN=1 LEFT=2 RIGHT=3)
//   game_reset              : one-cycle pulse on Space release
//   key_event               : one-cycle pulse per decoded key event
//   key_code/key_ext/key_break : details of the last event
module ps2_dir_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 500000,
    parameter bit          ALLOW_REVERSE  = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_code_new,
    input  logic [7:0] ps2_code,
    output logic [1:0] dir1,
    output logic [1:0] dir2,
    output logic       game_reset,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break
);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_EXT       = 2'd1;
    localparam logic [1:0] S_BREAK     = 2'd2;
    localparam logic [1:0] S_EXT_BREAK = 2'd3;

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          new_q, new_d;
    logic [1:0]    dir1_q, dir1_d;
    logic [1:0]    dir2_q, dir2_d;
    logic          gr_q, gr_d;
    logic          ev_q, ev_d;
    logic [7:0]    code_q, code_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;

    logic accept;
    logic is_fill;
    logic emit;
    logic e_ext;
    logic e_brk;

    // Opposite directions differ only in bit 0 with this encoding.
    function automatic logic [1:0] steer(input logic [1:0] cur,
                                         input logic [1:0] req);
        if (!ALLOW_REVERSE && (req == (cur ^ 2'b01)))
            return cur;
        return req;
    endfunction

    assign accept  = ps2_code_new & ~new_q;
    assign is_fill = (ps2_code == 8'h00) || (ps2_code == 8'hFF);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        new_d   = ps2_code_new;
        dir1_d  = dir1_q;
        dir2_d  = dir2_q;
        gr_d    = 1'b0;
        ev_d    = 1'b0;
        code_d  = code_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        emit    = 1'b0;
        e_ext   = 1'b0;
        e_brk   = 1'b0;

        if (accept) begin
            cnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (ps2_code == 8'hF0)      state_d = S_BREAK;
                    else if (ps2_code == 8'hE0) state_d = S_EXT;
                    else if (!is_fill)          emit = 1'b1;
                end
                S_EXT: begin
                    if (ps2_code == 8'hF0)      state_d = S_EXT_BREAK;
                    else if (ps2_code != 8'hE0) begin
                        state_d = S_IDLE;
                        emit    = !is_fill;
                        e_ext   = 1'b1;
                    end
                end
                S_BREAK: begin
                    if (ps2_code == 8'hE0)      state_d = S_EXT_BREAK;
                    else if (ps2_code != 8'hF0) begin
                        state_d = S_IDLE;
                        emit    = !is_fill;
                        e_brk   = 1'b1;
                    end
                end
                default: begin
                    if (ps2_code != 8'hF0 && ps2_code != 8'hE0) begin
                        state_d = S_IDLE;
                        emit    = !is_fill;
                        e_ext   = 1'b1;
                        e_brk   = 1'b1;
                    end
                end
            endcase
        end else if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Stale prefix: drop it silently.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (emit) begin
            ev_d   = 1'b1;
            code_d = ps2_code;
            ext_d  = e_ext;
            brk_d  = e_brk;
            if (!e_brk && !e_ext) begin
                case (ps2_code)
                    8'h1D:   dir1_d = steer(dir1_q, DIR_UP);
                    8'h1B:   dir1_d = steer(dir1_q, DIR_DOWN);
                    8'h1C:   dir1_d = steer(dir1_q, DIR_LEFT);
                    8'h23:   dir1_d = steer(dir1_q, DIR_RIGHT);
                    8'h29: begin
                        dir1_d = DIR_RIGHT;
                        dir2_d = DIR_LEFT;
                    end
                    default: ;
                endcase
            end
            if (!e_brk && e_ext) begin
                case (ps2_code)
                    8'h75:   dir2_d = steer(dir2_q, DIR_UP);
                    8'h72:   dir2_d = steer(dir2_q, DIR_DOWN);
                    8'h6B:   dir2_d = steer(dir2_q, DIR_LEFT);
                    8'h74:   dir2_d = steer(dir2_q, DIR_RIGHT);
                    default: ;
                endcase
            end
            if (e_brk && !e_ext && ps2_code == 8'h29)
                gr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            new_q   <= 1'b0;
            dir1_q  <= DIR_RIGHT;
            dir2_q  <= DIR_LEFT;
            gr_q    <= 1'b0;
            ev_q    <= 1'b0;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            new_q   <= new_d;
            dir1_q  <= dir1_d;
            dir2_q  <= dir2_d;
            gr_q    <= gr_d;
            ev_q    <= ev_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
        end
    end

    assign dir1       = dir1_q;
    assign dir2       = dir2_q;
    assign game_reset = gr_q;
    assign key_event  = ev_q;
    assign key_code   = code_q;
    assign key_ext    = ext_q;
    assign key_break  = brk_q;

endmodule
